// File: rtl/risc_p_pkg.sv
// Shared definitions for the risc_core_p multi-cycle core: opcodes, FSM state
// encoding and instruction field positions.
package risc_p_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR  = 4'h4, OP_XOR = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
    OP_LDI = 4'h8, OP_LD  = 4'h9, OP_ST  = 4'hA, OP_JMP = 4'hB,
    OP_JZ  = 4'hC, OP_JN  = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int W_MSB   = 11;
  localparam int W_LSB   = 9;
  localparam int R_MSB   = 8;
  localparam int R_LSB   = 6;
  localparam int S_MSB   = 5;
  localparam int S_LSB   = 3;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/risc_regfile.sv
// Eight-entry register file: two asynchronous read ports, one synchronous
// write port, cleared by the core reset.
module risc_regfile #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [2:0]    rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic          we,
    input  logic [2:0]    w_addr,
    input  logic [DW-1:0] w_data
);

    logic [DW-1:0] regs [8];

    // NOTE: the array is reset only because the core must start with r0..r7 = 0;
    // a large RAM-style store would normally be left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (we) begin
            regs[w_addr] <= w_data;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/risc_core_p.sv
// Multi-cycle 16-bit-ISA core: FETCH/DECODE/EXEC/MEM/HALT controller, ALU and
// N/Z/C flags, with a single handshaked memory port.
module risc_core_p
    import risc_p_pkg::*;
#(
    parameter int            DW     = 16,
    parameter logic [DW-1:0] RST_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] D_in,
    input  logic          mem_rdy,
    output logic          mr_en,
    output logic          mw_en,
    output logic [DW-1:0] Address,
    output logic [DW-1:0] D_out,
    output logic [7:0]    status,
    output logic          halt
);

    state_e        state, state_nxt;
    logic [DW-1:0] pc;
    logic [15:0]   ir;
    logic          flag_n, flag_z, flag_c;

    opcode_e       op;
    logic [2:0]    w_sel, r_sel, s_sel;
    logic [8:0]    imm9;
    logic [DW-1:0] imm_ext, r_val, s_val;

    logic [DW-1:0] alu_res;
    logic          alu_c, alu_wr, flags_wr;
    logic          reg_we;
    logic [DW-1:0] reg_wdata;

    assign op      = opcode_e'(ir[OP_MSB:OP_LSB]);
    assign w_sel   = ir[W_MSB:W_LSB];
    assign r_sel   = ir[R_MSB:R_LSB];
    assign s_sel   = ir[S_MSB:S_LSB];
    assign imm9    = ir[IMM_MSB:IMM_LSB];
    assign imm_ext = {{(DW-9){imm9[8]}}, imm9};

    risc_regfile #(.DW(DW)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (r_sel),
        .ra_data (r_val),
        .rb_addr (s_sel),
        .rb_data (s_val),
        .we      (reg_we),
        .w_addr  (w_sel),
        .w_data  (reg_wdata)
    );

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        alu_res  = '0;
        alu_c    = flag_c;
        alu_wr   = 1'b0;
        flags_wr = 1'b0;
        case (op)
            OP_ADD: begin {alu_c, alu_res} = {1'b0, r_val} + {1'b0, s_val}; alu_wr = 1'b1; flags_wr = 1'b1; end
            OP_SUB: begin alu_res = r_val - s_val; alu_c = (r_val < s_val); alu_wr = 1'b1; flags_wr = 1'b1; end
            OP_AND: begin alu_res = r_val & s_val; alu_c = 1'b0; alu_wr = 1'b1; flags_wr = 1'b1; end
            OP_OR:  begin alu_res = r_val | s_val; alu_c = 1'b0; alu_wr = 1'b1; flags_wr = 1'b1; end
            OP_XOR: begin alu_res = r_val ^ s_val; alu_c = 1'b0; alu_wr = 1'b1; flags_wr = 1'b1; end
            OP_SHL: begin alu_res = {r_val[DW-2:0], 1'b0}; alu_c = r_val[DW-1]; alu_wr = 1'b1; flags_wr = 1'b1; end
            OP_SHR: begin alu_res = {1'b0, r_val[DW-1:1]}; alu_c = r_val[0]; alu_wr = 1'b1; flags_wr = 1'b1; end
            OP_LDI: begin alu_res = imm_ext; alu_wr = 1'b1; end
            default: ;
        endcase
    end

    // Loads write the register file straight from the bus in MEM.
    assign reg_we    = ((state == S_EXEC) && alu_wr) ||
                       ((state == S_MEM) && (op == OP_LD) && mem_rdy);
    assign reg_wdata = (state == S_MEM) ? D_in : alu_res;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_rdy) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LD, OP_ST: state_nxt = S_MEM;
                    OP_HLT:       state_nxt = S_HALT;
                    default:      state_nxt = S_EXEC;
                endcase
            end
            S_EXEC:   state_nxt = S_FETCH;
            S_MEM:    if (mem_rdy) state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Bus outputs depend only on registered state, so they hold through waits.
    always_comb begin
        mr_en   = 1'b0;
        mw_en   = 1'b0;
        Address = pc;
        D_out   = '0;
        halt    = 1'b0;
        case (state)
            S_FETCH: mr_en = 1'b1;
            S_MEM: begin
                Address = r_val;
                if (op == OP_ST) begin
                    mw_en = 1'b1;
                    D_out = s_val;
                end else begin
                    mr_en = 1'b1;
                end
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RST_PC;
            ir     <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_rdy) begin
                        ir <= D_in[15:0];
                        pc <= pc + DW'(1);
                    end
                end
                S_EXEC: begin
                    if (flags_wr) begin
                        flag_n <= alu_res[DW-1];
                        flag_z <= (alu_res == '0);
                        flag_c <= alu_c;
                    end
                    case (op)
                        OP_JMP: pc <= r_val;
                        OP_JZ:  if (flag_z) pc <= pc + imm_ext;
                        OP_JN:  if (flag_n) pc <= pc + imm_ext;
                        OP_JC:  if (flag_c) pc <= pc + imm_ext;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign status = {1'b0, flag_n, flag_z, flag_c, 1'b0, state};

endmodule

// File: tb/tb_risc_core_p.sv
// Bench for risc_core_p: an instruction-level model predicts every bus cycle,
// driven by directed programs and random instruction streams.
module tb_risc_core_p;

    localparam logic [15:0] RST   = 16'h0010;
    localparam logic [31:0] RST32 = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_rdy, mr_en, mw_en, halt;
    logic [15:0] d_in, address, d_out;
    logic [7:0]  status;

    logic        reset32, mem_rdy32, mr32, mw32, halt32;
    logic [31:0] d_in32, addr32, dout32;
    logic [7:0]  status32;

    risc_core_p #(.DW(16), .RST_PC(RST)) u_dut (
        .clk(clk), .reset(reset), .D_in(d_in), .mem_rdy(mem_rdy),
        .mr_en(mr_en), .mw_en(mw_en), .Address(address), .D_out(d_out),
        .status(status), .halt(halt)
    );

    risc_core_p #(.DW(32), .RST_PC(RST32)) u_dut32 (
        .clk(clk), .reset(reset32), .D_in(d_in32), .mem_rdy(mem_rdy32),
        .mr_en(mr32), .mw_en(mw32), .Address(addr32), .D_out(dout32),
        .status(status32), .halt(halt32)
    );

    // ---------------- instruction-level model ----------------
    typedef enum {B_FETCH, B_IDLE, B_LD, B_ST, B_HALT} bus_e;

    bus_e        m_bus;
    int          m_idle;
    logic [15:0] m_regs [8];
    logic [15:0] m_pc, m_ir;
    logic        m_n, m_z, m_c;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] instr_q [$];
    logic [15:0] ld_q    [$];
    logic [15:0] fetch_log [$];
    bit          dir_mode;
    int          stall_mem;
    logic [15:0] st_addr_seen, st_data_seen;
    logic [7:0]  status_seen;
    int          st_cycles, halt_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_bus  = B_FETCH;
        m_idle = 0;
        m_pc   = RST;
        m_ir   = '0;
        m_n = 1'b0; m_z = 1'b0; m_c = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
    endtask

    task automatic exec_model();
        logic [15:0] r, s, res, off;
        logic [16:0] wide;
        bit          upd;
        r   = m_regs[m_ir[8:6]];
        s   = m_regs[m_ir[5:3]];
        off = {{7{m_ir[8]}}, m_ir[8:0]};
        res = '0;
        upd = 1'b1;
        case (m_ir[15:12])
            4'h1: begin wide = {1'b0, r} + {1'b0, s}; res = wide[15:0]; m_c = wide[16]; end
            4'h2: begin res = r - s; m_c = (r < s); end
            4'h3: begin res = r & s; m_c = 1'b0; end
            4'h4: begin res = r | s; m_c = 1'b0; end
            4'h5: begin res = r ^ s; m_c = 1'b0; end
            4'h6: begin res = r << 1; m_c = r[15]; end
            4'h7: begin res = r >> 1; m_c = r[0]; end
            default: upd = 1'b0;
        endcase
        if (upd) begin
            m_regs[m_ir[11:9]] = res;
            m_n = res[15];
            m_z = (res == 16'h0);
        end
        case (m_ir[15:12])
            4'h8: m_regs[m_ir[11:9]] = off;
            4'hB: m_pc = r;
            4'hC: if (m_z) m_pc = m_pc + off;
            4'hD: if (m_n) m_pc = m_pc + off;
            4'hE: if (m_c) m_pc = m_pc + off;
            default: ;
        endcase
    endtask

    // One clock: compare outputs against the model, drive memory, advance model.
    task automatic step();
        logic        emr, emw, eh, av, rdy;
        logic [2:0]  est;
        logic [15:0] edo, ea, word;
        logic [31:0] rnd;
        emr = 1'b0; emw = 1'b0; eh = 1'b0; av = 1'b0;
        est = 3'd0; edo = '0; ea = '0;
        case (m_bus)
            B_FETCH: begin emr = 1'b1; ea = m_pc; av = 1'b1; est = 3'd0; end
            B_IDLE:  est = (m_idle == 0) ? 3'd1 : 3'd2;
            B_LD:    begin emr = 1'b1; ea = m_regs[m_ir[8:6]]; av = 1'b1; est = 3'd3; end
            B_ST:    begin emw = 1'b1; ea = m_regs[m_ir[8:6]]; edo = m_regs[m_ir[5:3]]; av = 1'b1; est = 3'd3; end
            B_HALT:  begin eh = 1'b1; est = 3'd4; end
        endcase
        check("strobes", {mr_en, mw_en, halt}, {emr, emw, eh});
        check("status", status, {1'b0, m_n, m_z, m_c, 1'b0, est});
        check("d_out", d_out, edo);
        if (av) check("address", address, ea);

        if (mw_en) st_cycles++;
        if (halt) halt_seen++;
        status_seen = status;

        rdy = dir_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
        if ((m_bus == B_LD || m_bus == B_ST) && stall_mem > 0) begin
            rdy = 1'b0;
            stall_mem--;
        end
        rnd  = $urandom();
        word = rnd[15:0];
        if (rdy && m_bus == B_FETCH) begin
            if (instr_q.size() != 0) word = instr_q.pop_front();
            fetch_log.push_back(address);
        end
        if (rdy && m_bus == B_LD && ld_q.size() != 0) word = ld_q.pop_front();
        if (rdy && m_bus == B_ST) begin
            st_addr_seen = address;
            st_data_seen = d_out;
        end
        mem_rdy = rdy;
        d_in    = word;

        @(posedge clk);
        #1;

        case (m_bus)
            B_FETCH: if (rdy) begin m_ir = word; m_pc = m_pc + 16'd1; m_bus = B_IDLE; m_idle = 0; end
            B_IDLE: begin
                if (m_idle == 0) begin
                    case (m_ir[15:12])
                        4'h9:    m_bus = B_LD;
                        4'hA:    m_bus = B_ST;
                        4'hF:    m_bus = B_HALT;
                        default: m_idle = 1;
                    endcase
                end else begin
                    exec_model();
                    m_bus = B_FETCH;
                end
            end
            B_LD:   if (rdy) begin m_regs[m_ir[11:9]] = word; m_bus = B_FETCH; end
            B_ST:   if (rdy) m_bus = B_FETCH;
            B_HALT: ;
        endcase
    endtask

    task automatic drain();
        int guard = 0;
        while ((instr_q.size() != 0 || m_bus != B_FETCH) && guard < 500) begin
            step();
            guard++;
        end
        check("drain_in_budget", guard < 500, 1'b1);
    endtask

    // Entered just after a rising edge; reset is applied between edges.
    task automatic do_reset();
        reset   = 1'b0;
        mem_rdy = 1'b0;
        #1;
        check("rst_mr_en", mr_en, 1'b1);
        check("rst_address", address, RST);
        check("rst_status", status, 8'h00);
        check("rst_mw_halt_dout", {mw_en, halt, d_out}, 18'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic bus32(input string name, input logic [31:0] exp_addr, input logic [31:0] data);
        int g = 0;
        while (!mr32 && g < 10) begin
            @(posedge clk); #1;
            g++;
        end
        check({name, "_in_budget"}, g < 10, 1'b1);
        check({name, "_addr"}, addr32, exp_addr);
        mem_rdy32 = 1'b1;
        d_in32    = data;
        @(posedge clk); #1;
        mem_rdy32 = 1'b0;
        d_in32    = 32'hDEAD_BEEF;
    endtask

    task automatic wait_mem32(input string name);
        int g = 0;
        while (status32[2:0] != 3'd3 && g < 10) begin
            @(posedge clk); #1;
            g++;
        end
        check({name, "_in_budget"}, g < 10, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hc;
        reset = 1'b0; mem_rdy = 1'b0; d_in = '0;
        reset32 = 1'b0; mem_rdy32 = 1'b0; d_in32 = '0;
        dir_mode = 1'b1; stall_mem = 0; st_cycles = 0; halt_seen = 0;
        st_addr_seen = '0; st_data_seen = '0; status_seen = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("por_mr_en", mr_en, 1'b1);
        check("por_address", address, RST);
        check("por_status", status, 8'h00);
        check("por_mw_halt_dout", {mw_en, halt, d_out}, 18'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // LDI r1,5; LDI r2,3; SUB r3,r1,r2; ST [r2],r3 with a 3-cycle stall
        instr_q = '{16'h8205, 16'h8403, 16'h2650, 16'hA098};
        stall_mem = 3; st_cycles = 0;
        drain();
        check("sub_result", st_data_seen, 16'h0002);
        check("sub_st_addr", st_addr_seen, 16'h0003);
        check("sub_flags", status_seen[6:4], 3'b000);
        check("st_wait_cycles", st_cycles, 4);

        // r1=FFFF + r2=1 -> 0 with Z,C; JZ +2 skips two words
        do_reset();
        fetch_log.delete();
        instr_q = '{16'h83FF, 16'h8401, 16'h1650, 16'hC002, 16'h0000};
        drain();
        check("add_flags", status_seen[6:4], 3'b011);
        check("jz_fetch_count", fetch_log.size(), 5);
        if (fetch_log.size() >= 5) begin
            check("jz_src", fetch_log[3], 16'h0013);
            check("jz_target", fetch_log[4], 16'h0016);
        end

        // LD r4 from 0x0040 returning 0x1234, store it back out
        instr_q = '{16'h8240, 16'h9840, 16'hA060};
        ld_q    = '{16'h1234};
        drain();
        check("ld_value", st_data_seen, 16'h1234);
        check("ld_addr", st_addr_seen, 16'h0040);
        check("ld_flags_kept", status_seen[6:4], 3'b011);

        // HLT is absorbing
        instr_q = '{16'hF000};
        hc = 0;
        while (m_bus != B_HALT && hc < 20) begin step(); hc++; end
        halt_seen = 0;
        repeat (20) step();
        check("halt_cycles", halt_seen, 20);
        check("halt_state", status_seen[2:0], 3'd4);
        do_reset();

        // Reset during a stalled load abandons it; registers read back as zero
        instr_q = '{16'h8A07, 16'h9D40};
        stall_mem = 1000;
        hc = 0;
        while (m_bus != B_LD && hc < 50) begin step(); hc++; end
        check("ld_wait_reached", m_bus == B_LD, 1'b1);
        step(); step();
        do_reset();
        stall_mem = 0;
        instr_q.delete();
        ld_q.delete();
        instr_q = '{16'hA168};
        drain();
        check("post_rst_r5_addr", st_addr_seen, 16'h0000);
        check("post_rst_r5_data", st_data_seen, 16'h0000);

        // Random instruction streams with random wait states
        dir_mode = 1'b0;
        hc = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (m_bus == B_HALT) begin
                hc++;
                if (hc >= 20) begin do_reset(); hc = 0; end
            end
        end
        mem_rdy = 1'b0;

        // DW=32: jump to the top of the address space and wrap
        @(negedge clk);
        reset32 = 1'b1;
        @(posedge clk); #1;
        bus32("w_ldi", RST32, 32'h0000_83FF);
        bus32("w_jmp", RST32 + 32'd1, 32'h0000_B040);
        bus32("w_top", 32'hFFFF_FFFF, 32'h0000_0000);
        bus32("w_wrap", 32'h0000_0000, 32'h0000_9840);
        wait_mem32("w_ld");
        check("w_ld_addr", addr32, 32'hFFFF_FFFF);
        check("w_ld_mr_en", mr32, 1'b1);
        reset32 = 1'b0;
        #1;
        check("w_rst_status", status32, 8'h00);
        check("w_rst_addr", addr32, RST32);
        check("w_rst_strobes", {mr32, mw32, halt32}, 3'b100);
        check("w_rst_dout", dout32, 32'h0);
        @(negedge clk);
        reset32 = 1'b1;
        @(posedge clk); #1;
        bus32("w_st", RST32, 32'h0000_A048);
        wait_mem32("w_st");
        check("w_st_cleared", {mw32, addr32, dout32}, {1'b1, 32'h0, 32'h0});
        mem_rdy32 = 1'b1;
        @(posedge clk); #1;
        mem_rdy32 = 1'b0;
        check("w_st_done_fetch", {mr32, mw32, status32[2:0]}, {1'b1, 1'b0, 3'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
